// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin channel mux.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width for n channels; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant selection: fixed channel select or round-robin search from ptr.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IW  = idx_w(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  ptr,
   input  logic           mode,
   input  logic [IW-1:0]  sel,
   output logic [NCH-1:0] grant,
   output logic [IW-1:0]  idx
);

   logic found;
   int   c;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      if (mode == MODE_FIXED) begin
         // sel beyond the last channel grants nothing
         if (int'(sel) < NCH) begin
            if (req[sel]) begin
               grant[sel] = 1'b1;
               idx        = sel;
            end
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            c = int'(ptr) + k;
            if (c >= NCH) c = c - NCH;
            if (!found && req[c]) begin
               found    = 1'b1;
               grant[c] = 1'b1;
               idx      = IW'(c);
            end
         end
      end
   end

endmodule

// File: rtl/rr_mux.sv
// Registered N-channel mux with fixed or round-robin selection.
// Optional out_parity output when RR_MUX_PARITY_EN is defined.
module rr_mux
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NCH-1:0]           in_valid,
   input  logic [NCH*WIDTH-1:0]     in_data,
   output logic [NCH-1:0]           in_ready,
   input  logic                     mode,
   input  logic [idx_w(NCH)-1:0]    sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [idx_w(NCH)-1:0]    out_ch
`ifdef RR_MUX_PARITY_EN
   ,
   output logic                     out_parity
`endif
);

   localparam int IW = idx_w(NCH);

   logic [NCH-1:0]   grant;
   logic [IW-1:0]    gidx;
   logic [IW-1:0]    ptr;
   logic             can_load;
   logic             accept;
   logic [WIDTH-1:0] data_next;

   rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
      .req   (in_valid),
      .ptr   (ptr),
      .mode  (mode),
      .sel   (sel),
      .grant (grant),
      .idx   (gidx)
   );

   // Output register may take a word when empty or draining this cycle.
   assign can_load  = !reset && (!out_valid || out_ready);
   assign in_ready  = can_load ? grant : '0;
   assign accept    = |in_ready;
   assign data_next = in_data[int'(gidx)*WIDTH +: WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= data_next;
         out_ch    <= gidx;
         ptr       <= (int'(gidx) == NCH - 1) ? '0 : IW'(int'(gidx) + 1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef RR_MUX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         out_parity <= 1'b0;
      end else if (accept) begin
         out_parity <= ^data_next;
      end
   end
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Directed self-checking bench for rr_mux (4 channels x 32 bits).
module tb_rr_mux;

   logic         clk;
   logic         reset;
   logic [3:0]   in_valid;
   logic [127:0] in_data;
   logic [3:0]   in_ready;
   logic         mode;
   logic [1:0]   sel;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_ch;
`ifdef RR_MUX_PARITY_EN
   logic         out_parity;
`endif

   int vectors;
   int miscompares;

   rr_mux #(.WIDTH(32), .NCH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch)
`ifdef RR_MUX_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] dval(input int n, input int c);
      return 32'hAB00_0000 + 32'(n * 256 + c);
   endfunction

   task automatic load(input int n);
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = dval(n, i);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      in_valid    = 4'b1111;
      mode        = 1'b0;
      sel         = 2'd2;
      out_ready   = 1'b1;
      load(0);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_ch", 32'(out_ch), 32'h0);
      chk("rst_in_ready2", 32'(in_ready), 32'h0);

      // fixed mode, sel=2, all channels requesting
      reset = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         load(n);
         #1;
         chk("fix_in_ready", 32'(in_ready), 32'h4);
         step();
         chk("fix_out_valid", 32'(out_valid), 32'h1);
         chk("fix_out_ch", 32'(out_ch), 32'h2);
         chk("fix_out_data", out_data, dval(n, 2));
      end
      sel = 2'd1;
      #1;
      chk("fix_sel1", 32'(in_ready), 32'h2);
      in_valid = 4'b1101;
      #1;
      chk("fix_sel1_noreq", 32'(in_ready), 32'h0);

      // reset with a word held, then round-robin from channel 0
      in_valid = 4'b1111;
      sel      = 2'd2;
      #1;
      chk("pre_rst_valid", 32'(out_valid), 32'h1);
      reset = 1'b1;
      #1;
      chk("rst_comb_ready", 32'(in_ready), 32'h0);
      step();
      chk("rst2_out_valid", 32'(out_valid), 32'h0);
      chk("rst2_in_ready", 32'(in_ready), 32'h0);
      reset = 1'b0;
      mode  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         load(10 + k);
         #1;
         chk("rr_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
         step();
         chk("rr_out_ch", 32'(out_ch), 32'(k % 4));
         chk("rr_out_data", out_data, dval(10 + k, k % 4));
      end

      // ptr=1, only channels 0 and 3 requesting: 3, 0, 3
      in_valid = 4'b1001;
      load(20);
      #1;
      chk("wrap_ready_a", 32'(in_ready), 32'h8);
      step();
      chk("wrap_ch_a", 32'(out_ch), 32'h3);
      chk("wrap_ready_b", 32'(in_ready), 32'h1);
      step();
      chk("wrap_ch_b", 32'(out_ch), 32'h0);
      chk("wrap_ready_c", 32'(in_ready), 32'h8);
      step();
      chk("wrap_ch_c", 32'(out_ch), 32'h3);
      chk("wrap_data_c", out_data, dval(20, 3));

      // backpressure for three cycles, then release
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         load(30 + k);
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         step();
         chk("bp_out_valid", 32'(out_valid), 32'h1);
         chk("bp_out_ch", 32'(out_ch), 32'h3);
         chk("bp_out_data", out_data, dval(20, 3));
      end
      out_ready = 1'b1;
      load(40);
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'h1);
      step();
      chk("rel_out_ch", 32'(out_ch), 32'h0);
      chk("rel_out_data", out_data, dval(40, 0));
      chk("rel_out_valid", 32'(out_valid), 32'h1);

      // drain with no new input, ptr holds at 1
      in_valid = 4'b0000;
      step();
      chk("drain_valid", 32'(out_valid), 32'h0);
      step();
      chk("idle_ch_hold", 32'(out_ch), 32'h0);
      in_valid  = 4'b1001;
      out_ready = 1'b0;
      #1;
      chk("empty_ready", 32'(in_ready), 32'h8);
      load(50);
      step();
      chk("empty_load_ch", 32'(out_ch), 32'h3);
      chk("full_no_ready", 32'(in_ready), 32'h0);

      // mode change while a word is held does not disturb it
      mode = 1'b0;
      sel  = 2'd0;
      step();
      chk("mchg_ch_hold", 32'(out_ch), 32'h3);
      chk("mchg_data_hold", out_data, dval(50, 3));
      out_ready = 1'b1;
      #1;
      chk("mchg_ready", 32'(in_ready), 32'h1);
      step();
      chk("mchg_ch", 32'(out_ch), 32'h0);

`ifdef RR_MUX_PARITY_EN
      in_valid = 4'b0001;
      in_data[31:0] = 32'h0000_0007;
      step();
      chk("parity_7", 32'(out_parity), 32'h1);
      in_data[31:0] = 32'h0000_0003;
      step();
      chk("parity_3", 32'(out_parity), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
